johnson_decoder_monitor: RTL

Receive-side companion to the team's Johnson counter. Samples an N-bit Johnson-coded word and decodes it to a binary state index. Checks each word for code legality and checks that successive words follow the Johnson sequence. Maintains a lock state and a saturating error count, so a downstream block or bench can trust or flag the counter output.

---
 rtl/johnson_decoder_monitor.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/johnson_decoder_monitor.sv
`default_nettype none
// johnson_decoder_monitor: decodes Johnson-coded words to a state index, tracks
// sequence lock and keeps a saturating error count.  Rev 1.0
module johnson_decoder_monitor #(
   parameter int N          = 4,
   parameter int LOCK_LEN   = 2,
   parameter int ALLOW_HOLD = 1,
   parameter int ECW        = 8,
   localparam int IW        = $clog2(2*N)
) (
   input  logic           clk_i,
   input  logic           clr_ni,
   input  logic           valid_i,
   input  logic [N-1:0]   jcode_i,
   output logic           valid_o,
   output logic [IW-1:0]  index_o,
   output logic           legal_o,
   output logic           seq_err_o,
   output logic           locked_o,
   output logic [ECW-1:0] err_count_o
);

   localparam logic [1:0]   S_HUNT = 2'd0;
   localparam logic [1:0]   S_ACQ  = 2'd1;
   localparam logic [1:0]   S_LOCK = 2'd2;
   localparam logic [N-1:0] C_ONE  = N'(1);
   localparam logic [3:0]   C_LOCK = 4'(LOCK_LEN);

   logic [1:0]     state_q, state_d;
   logic [3:0]     acq_q, acq_d;
   logic [IW-1:0]  index_q, index_d;
   logic           valid_q, valid_d;
   logic           legal_q, legal_d;
   logic           seq_err_q, seq_err_d;
   logic           locked_q, locked_d;
   logic [ECW-1:0] err_cnt_q, err_cnt_d;

   logic [N-1:0]   therm_w;
   logic [IW-1:0]  pop_w;
   logic [IW-1:0]  idx_w;
   logic [IW-1:0]  succ_w;
   logic [3:0]     acq_inc_w;
   logic           legal_w;
   logic           in_seq_w;
   logic           hold_ok_w;
   logic           err_w;

   // Fold the upper half of the sequence onto a plain thermometer code.
   assign therm_w = jcode_i[N-1] ? ~jcode_i : jcode_i;
   assign legal_w = ((therm_w & (therm_w + C_ONE)) == '0);

   always_comb begin
      pop_w = '0;
      for (int b = 0; b < N; b++) begin
         pop_w = pop_w + IW'(jcode_i[b]);
      end
   end

   assign idx_w     = jcode_i[N-1] ? (IW'(2*N) - pop_w) : pop_w;
   assign succ_w    = (index_q == IW'(2*N-1)) ? '0 : (index_q + IW'(1));
   assign in_seq_w  = (idx_w == succ_w);
   assign hold_ok_w = (ALLOW_HOLD != 0) && (idx_w == index_q);
   assign acq_inc_w = acq_q + 4'd1;

   always_ff @(posedge clk_i or negedge clr_ni) begin
      if (!clr_ni) begin
         state_q   <= S_HUNT;
         acq_q     <= '0;
         index_q   <= '0;
         valid_q   <= 1'b0;
         legal_q   <= 1'b0;
         seq_err_q <= 1'b0;
         locked_q  <= 1'b0;
         err_cnt_q <= '0;
      end else begin
         state_q   <= state_d;
         acq_q     <= acq_d;
         index_q   <= index_d;
         valid_q   <= valid_d;
         legal_q   <= legal_d;
         seq_err_q <= seq_err_d;
         locked_q  <= locked_d;
         err_cnt_q <= err_cnt_d;
      end
   end

   always_comb begin
      state_d = state_q;
      acq_d   = acq_q;
      err_w   = 1'b0;
      if (valid_i) begin
         if (!legal_w) begin
            state_d = S_HUNT;
            err_w   = 1'b1;
         end else begin
            case (state_q)
               S_HUNT: begin
                  state_d = S_ACQ;
                  acq_d   = '0;
               end
               S_ACQ: begin
                  if (in_seq_w) begin
                     acq_d = acq_inc_w;
                     if (acq_inc_w == C_LOCK) state_d = S_LOCK;
                  end else if (!hold_ok_w) begin
                     acq_d = '0;
                  end
               end
               S_LOCK: begin
                  if (!(in_seq_w || hold_ok_w)) begin
                     state_d = S_ACQ;
                     acq_d   = '0;
                     err_w   = 1'b1;
                  end
               end
               default: state_d = S_HUNT;
            endcase
         end
      end
   end

   // index_q doubles as the sequence reference: both follow the last legal sample.
   always_comb begin
      valid_d   = valid_i;
      seq_err_d = err_w;
      index_d   = index_q;
      legal_d   = legal_q;
      err_cnt_d = err_cnt_q;
      locked_d  = (state_d == S_LOCK);
      if (valid_i) begin
         legal_d = legal_w;
         if (legal_w) index_d = idx_w;
         if (err_w && (err_cnt_q != '1)) err_cnt_d = err_cnt_q + ECW'(1);
      end
   end

   assign valid_o     = valid_q;
   assign index_o     = index_q;
   assign legal_o     = legal_q;
   assign seq_err_o   = seq_err_q;
   assign locked_o    = locked_q;
   assign err_count_o = err_cnt_q;

endmodule
`default_nettype wire
